// File: rtl/seg_scan_pkg.sv
// Shared constants and types for the multiplexed seven-segment scan display.
// Glyph bytes are {dp,g,f,e,d,c,b,a}, active-high.
package seg_scan_pkg;

  localparam logic [7:0] SEG_BLANK = 8'h00;
  localparam logic [7:0] GLYPH_0   = 8'h3F;
  localparam logic [7:0] GLYPH_1   = 8'h06;
  localparam logic [7:0] GLYPH_2   = 8'h5B;
  localparam logic [7:0] GLYPH_3   = 8'h4F;
  localparam logic [7:0] GLYPH_4   = 8'h66;
  localparam logic [7:0] GLYPH_5   = 8'h6D;
  localparam logic [7:0] GLYPH_6   = 8'h7D;
  localparam logic [7:0] GLYPH_7   = 8'h07;
  localparam logic [7:0] GLYPH_8   = 8'h7F;
  localparam logic [7:0] GLYPH_9   = 8'h6F;
  localparam logic [7:0] GLYPH_A   = 8'h77;
  localparam logic [7:0] GLYPH_B   = 8'h7C;
  localparam logic [7:0] GLYPH_C   = 8'h39;
  localparam logic [7:0] GLYPH_D   = 8'h5E;
  localparam logic [7:0] GLYPH_E   = 8'h79;
  localparam logic [7:0] GLYPH_F   = 8'h71;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  function automatic logic [7:0] hex_glyph(input logic [3:0] nib);
    case (nib)
      4'h0:    hex_glyph = GLYPH_0;
      4'h1:    hex_glyph = GLYPH_1;
      4'h2:    hex_glyph = GLYPH_2;
      4'h3:    hex_glyph = GLYPH_3;
      4'h4:    hex_glyph = GLYPH_4;
      4'h5:    hex_glyph = GLYPH_5;
      4'h6:    hex_glyph = GLYPH_6;
      4'h7:    hex_glyph = GLYPH_7;
      4'h8:    hex_glyph = GLYPH_8;
      4'h9:    hex_glyph = GLYPH_9;
      4'hA:    hex_glyph = GLYPH_A;
      4'hB:    hex_glyph = GLYPH_B;
      4'hC:    hex_glyph = GLYPH_C;
      4'hD:    hex_glyph = GLYPH_D;
      4'hE:    hex_glyph = GLYPH_E;
      4'hF:    hex_glyph = GLYPH_F;
      default: hex_glyph = SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/seg_hex_decode.sv
// Combinational nibble-to-glyph decoder with a blanking override.
module seg_hex_decode
  import seg_scan_pkg::*;
(
  input  logic [3:0] i_nibble,
  input  logic       i_blank,
  output logic [7:0] o_seg
);

  // Blank wins over the glyph lookup
  always_comb begin
    if (i_blank) begin
      o_seg = SEG_BLANK;
    end else begin
      o_seg = hex_glyph(i_nibble);
    end
  end

endmodule

// File: rtl/seg_scan_display.sv
// Banked hex value store scanned one slot at a time onto per-bank digit groups.
// Optional leading-zero blanking is enabled by defining SEG_SCAN_LZ_BLANK_EN.
module seg_scan_display
  import seg_scan_pkg::*;
#(
  parameter int NUM_SLOTS = 8,
  parameter int NUM_BANKS = 2,
  parameter int DIGITS    = 4,
  parameter int SCAN_DIV  = 1024,
  localparam int SLOT_W   = $clog2(NUM_SLOTS),
  localparam int BANK_W   = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1,
  localparam int VAL_W    = DIGITS * 4,
  localparam int SEG_W    = NUM_BANKS * DIGITS * 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [SLOT_W-1:0] wr_slot,
  input  logic [BANK_W-1:0] wr_bank,
  input  logic [VAL_W-1:0]  wr_data,
  input  logic              clr,
  output logic [SEG_W-1:0]  seg,
  output logic [NUM_SLOTS-1:0] slot_sel,
  output logic              busy
);

  localparam int DIV_W = $clog2(SCAN_DIV);

  state_t                r_state;
  logic [SLOT_W-1:0]     r_sweep_idx;
  logic                  r_wr_ready;
  logic                  r_busy;
  logic [DIV_W-1:0]      r_presc;
  logic [SLOT_W-1:0]     r_scan_idx;
  logic [VAL_W-1:0]      r_value [NUM_BANKS][NUM_SLOTS];
  logic [NUM_SLOTS-1:0]  r_valid [NUM_BANKS];
  logic [SEG_W-1:0]      r_seg;
  logic [NUM_SLOTS-1:0]  r_slot_sel;
  logic [SEG_W-1:0]      w_seg;
  logic                  w_wr_fire;

  assign w_wr_fire = wr_valid & r_wr_ready;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_sweep_idx <= '0;
      r_wr_ready  <= 1'b1;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (clr) begin
            r_state     <= CLEAR;
            r_sweep_idx <= '0;
            r_wr_ready  <= 1'b0;
            r_busy      <= 1'b1;
          end
        end
        CLEAR: begin
          if (int'(r_sweep_idx) == NUM_SLOTS - 1) begin
            r_state     <= IDLE;
            r_sweep_idx <= '0;
            r_wr_ready  <= 1'b1;
            r_busy      <= 1'b0;
          end else begin
            r_sweep_idx <= r_sweep_idx + SLOT_W'(1);
          end
        end
        default: begin
          r_state     <= IDLE;
          r_sweep_idx <= '0;
          r_wr_ready  <= 1'b1;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  // Out-of-range slot/bank writes match no entry, so they are dropped silently
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        r_valid[b] <= '0;
        for (int s = 0; s < NUM_SLOTS; s++) begin
          r_value[b][s] <= '0;
        end
      end
    end else begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        for (int s = 0; s < NUM_SLOTS; s++) begin
          if (r_state == CLEAR && s == int'(r_sweep_idx)) begin
            r_valid[b][s] <= 1'b0;
            r_value[b][s] <= '0;
          end else if (w_wr_fire && b == int'(wr_bank) && s == int'(wr_slot)) begin
            r_valid[b][s] <= 1'b1;
            r_value[b][s] <= wr_data;
          end
        end
      end
    end
  end

  // Scan prescaler and slot index run in every state
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_presc    <= '0;
      r_scan_idx <= '0;
    end else if (int'(r_presc) == SCAN_DIV - 1) begin
      r_presc <= '0;
      if (int'(r_scan_idx) == NUM_SLOTS - 1) begin
        r_scan_idx <= '0;
      end else begin
        r_scan_idx <= r_scan_idx + SLOT_W'(1);
      end
    end else begin
      r_presc <= r_presc + DIV_W'(1);
    end
  end

  genvar gb, gd;
  generate
    for (gb = 0; gb < NUM_BANKS; gb++) begin : g_bank
      logic [VAL_W-1:0] w_value;
      logic             w_valid;
      assign w_value = r_value[gb][r_scan_idx];
      assign w_valid = r_valid[gb][r_scan_idx];
      for (gd = 0; gd < DIGITS; gd++) begin : g_digit
        logic w_lead_zero;
        logic w_blank;
`ifdef SEG_SCAN_LZ_BLANK_EN
        // The rightmost digit always shows, so a zero value reads "0"
        if (gd < DIGITS - 1) begin : g_lz
          assign w_lead_zero = (w_value[VAL_W-1 -: 4*(gd+1)] == '0);
        end else begin : g_last
          assign w_lead_zero = 1'b0;
        end
`else
        assign w_lead_zero = 1'b0;
`endif
        assign w_blank = ~w_valid | w_lead_zero;
        seg_hex_decode u_dec (
          .i_nibble (w_value[VAL_W-1-4*gd -: 4]),
          .i_blank  (w_blank),
          .o_seg    (w_seg[(NUM_BANKS*DIGITS-1-(gb*DIGITS+gd))*8 +: 8])
        );
      end
    end
  endgenerate

  // One-cycle registered display outputs
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_seg      <= '0;
      r_slot_sel <= NUM_SLOTS'(1);
    end else begin
      r_seg      <= w_seg;
      r_slot_sel <= NUM_SLOTS'(1) << r_scan_idx;
    end
  end

  assign seg      = r_seg;
  assign slot_sel = r_slot_sel;
  assign wr_ready = r_wr_ready;
  assign busy     = r_busy;

endmodule

// File: tb/tb_seg_scan_display.sv
// Self-checking bench for seg_scan_display against a cycle-count reference model.
module tb_seg_scan_display;

  localparam int NS = 8;
  localparam int NB = 2;
  localparam int DG = 4;
  localparam int SD = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [2:0]  wr_slot = 3'd0;
  logic [0:0]  wr_bank = 1'b0;
  logic [15:0] wr_data = 16'h0;
  logic        clr = 1'b0;
  logic [63:0] seg;
  logic [7:0]  slot_sel;
  logic        busy;

  logic        wr_valid1 = 1'b0;
  logic        wr_ready1;
  logic [2:0]  wr_slot1 = 3'd0;
  logic [0:0]  wr_bank1 = 1'b0;
  logic [7:0]  wr_data1 = 8'h0;
  logic        clr1 = 1'b0;
  logic [15:0] seg1;
  logic [5:0]  slot_sel1;
  logic        busy1;

  logic [7:0] glyph [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                             8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};

  logic [15:0] m_val [NB][NS];
  bit          m_vld [NB][NS];
  bit          m_busy;
  int          m_sweep;
  int          m_cnt;
  int          cmp_count;
  int          err_count;

  seg_scan_display #(.NUM_SLOTS(NS), .NUM_BANKS(NB), .DIGITS(DG), .SCAN_DIV(SD)) u_dut (
    .clock(clock), .reset(reset), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_slot(wr_slot), .wr_bank(wr_bank), .wr_data(wr_data), .clr(clr),
    .seg(seg), .slot_sel(slot_sel), .busy(busy)
  );

  seg_scan_display #(.NUM_SLOTS(6), .NUM_BANKS(1), .DIGITS(2), .SCAN_DIV(2)) u_dut1 (
    .clock(clock), .reset(reset), .wr_valid(wr_valid1), .wr_ready(wr_ready1),
    .wr_slot(wr_slot1), .wr_bank(wr_bank1), .wr_data(wr_data1), .clr(clr1),
    .seg(seg1), .slot_sel(slot_sel1), .busy(busy1)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    cmp_count++;
    assert (obs === exp) else begin
      err_count++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0;
    m_busy = 1'b0;
    m_sweep = 0;
    for (int b = 0; b < NB; b++)
      for (int s = 0; s < NS; s++) begin
        m_val[b][s] = 16'h0;
        m_vld[b][s] = 1'b0;
      end
  endtask

  function automatic logic [63:0] exp_seg(input int slot);
    logic [63:0] r;
    logic [15:0] shifted;
    bit          blank;
    r = 64'h0;
    for (int b = 0; b < NB; b++) begin
      for (int d = 0; d < DG; d++) begin
        shifted = m_val[b][slot] >> (4 * (DG - 1 - d));
        blank = !m_vld[b][slot];
`ifdef SEG_SCAN_LZ_BLANK_EN
        if (d < DG - 1 && shifted == 16'h0) blank = 1'b1;
`endif
        r[(NB*DG-1-(b*DG+d))*8 +: 8] = blank ? 8'h00 : glyph[shifted[3:0]];
      end
    end
    return r;
  endfunction

  // One clock: predict outputs from pre-edge state, apply edge to model, compare.
  task automatic tick();
    logic [63:0] e_seg;
    logic [7:0]  e_sel;
    int          scan;
    scan  = (m_cnt / SD) % NS;
    e_seg = exp_seg(scan);
    e_sel = 8'(1 << scan);
    @(posedge clock);
    if (m_busy) begin
      for (int b = 0; b < NB; b++) begin
        m_vld[b][m_sweep] = 1'b0;
        m_val[b][m_sweep] = 16'h0;
      end
      if (m_sweep == NS - 1) m_busy = 1'b0;
      else m_sweep++;
    end else begin
      if (wr_valid && int'(wr_slot) < NS && int'(wr_bank) < NB) begin
        m_val[wr_bank][wr_slot] = wr_data;
        m_vld[wr_bank][wr_slot] = 1'b1;
      end
      if (clr) begin
        m_busy = 1'b1;
        m_sweep = 0;
      end
    end
    m_cnt++;
    @(negedge clock);
    check("seg", seg, e_seg);
    check("slot_sel", 64'(slot_sel), 64'(e_sel));
    check("wr_ready", 64'(wr_ready), 64'(!m_busy));
    check("busy", 64'(busy), 64'(m_busy));
  endtask

  task automatic wait_sel(input logic [7:0] target);
    int n;
    n = 0;
    while (slot_sel !== target && n < 80) begin
      tick();
      n++;
    end
    check("wait_slot_sel", 64'(slot_sel), 64'(target));
  endtask

  task automatic wait_sel1(input logic [5:0] target);
    int n;
    n = 0;
    while (slot_sel1 !== target && n < 40) begin
      tick();
      n++;
    end
    check("wait_slot_sel1", 64'(slot_sel1), 64'(target));
  endtask

  task automatic write0(input int slot, input int bank, input logic [15:0] data);
    wr_valid = 1'b1;
    wr_slot  = 3'(slot);
    wr_bank  = 1'(bank);
    wr_data  = data;
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic write1(input int slot, input int bank, input logic [7:0] data);
    check("dut1_ready_before_write", 64'(wr_ready1), 64'd1);
    wr_valid1 = 1'b1;
    wr_slot1  = 3'(slot);
    wr_bank1  = 1'(bank);
    wr_data1  = data;
    tick();
    wr_valid1 = 1'b0;
  endtask

  initial begin
    int n;
    int lo;
    int busy_hi;
    logic [63:0] lz_exp;
    cmp_count = 0;
    err_count = 0;
    model_reset();

    // Reset values
    reset = 1'b1;
    @(posedge clock);
    #1;
    check("rst_seg", seg, 64'h0);
    check("rst_slot_sel", 64'(slot_sel), 64'h01);
    check("rst_wr_ready", 64'(wr_ready), 64'd1);
    check("rst_busy", 64'(busy), 64'd0);
    @(negedge clock);
    reset = 1'b0;
    repeat (5) tick();

    // Single write shown on its slot
    write0(3, 0, 16'h12AF);
    wait_sel(8'h08);
    check("glyphs_12AF", seg, {8'h06, 8'h5B, 8'h77, 8'h71, 32'h0});

    // Scan step and wrap period
    wait_sel(8'h80);
    n = 0;
    while (slot_sel !== 8'h01 && n < 100) begin tick(); n++; end
    check("wrap_step_cycles", 64'(n), 64'(SD));
    n = 0;
    do begin tick(); n++; end while (slot_sel === 8'h01 && n < 100);
    while (slot_sel !== 8'h01 && n < 100) begin tick(); n++; end
    check("scan_period_cycles", 64'(n), 64'(SD * NS));

    // Random traffic
    repeat (60) begin
      wr_valid = 1'($urandom_range(0, 1));
      wr_slot  = 3'($urandom);
      wr_bank  = 1'($urandom);
      wr_data  = 16'($urandom);
      tick();
    end
    wr_valid = 1'b0;
    repeat (40) tick();

    // Fill every slot, then clear together with a write
    for (int s = 0; s < NS; s++)
      for (int b = 0; b < NB; b++)
        write0(s, b, 16'($urandom) | 16'h1000);
    wr_valid = 1'b1;
    wr_slot  = 3'd2;
    wr_bank  = 1'b1;
    wr_data  = 16'hBEEF;
    clr      = 1'b1;
    tick();
    wr_valid = 1'b0;
    lo = 0;
    busy_hi = 0;
    n = 0;
    while (wr_ready === 1'b0 && n < 20) begin
      lo++;
      if (busy === 1'b1) busy_hi++;
      tick();
      clr = (n < 2) ? 1'b1 : 1'b0;
      n++;
    end
    clr = 1'b0;
    check("clear_ready_low_cycles", 64'(lo), 64'(NS));
    check("clear_busy_high_cycles", 64'(busy_hi), 64'(NS));
    repeat (34) tick();
    wait_sel(8'h04);
    check("cleared_slot2_seg", seg, 64'h0);

    // Leading-zero behaviour
    write0(5, 0, 16'h0000);
    write0(5, 1, 16'h0050);
    wait_sel(8'h20);
`ifdef SEG_SCAN_LZ_BLANK_EN
    lz_exp = {8'h00, 8'h00, 8'h00, 8'h3F, 8'h00, 8'h00, 8'h6D, 8'h3F};
`else
    lz_exp = {8'h3F, 8'h3F, 8'h3F, 8'h3F, 8'h3F, 8'h3F, 8'h6D, 8'h3F};
`endif
    check("lz_slot5", seg, lz_exp);

    // 1-bank, 6-slot instance: out-of-range writes are accepted and dropped
    write1(2, 0, 8'h3C);
    write1(4, 0, 8'h05);
    write1(6, 0, 8'h99);
    write1(7, 0, 8'h11);
    write1(2, 1, 8'h77);
    check("dut1_ready_after", 64'(wr_ready1), 64'd1);
    check("dut1_busy", 64'(busy1), 64'd0);
    wait_sel1(6'b000100);
    check("dut1_slot2", 64'(seg1), 64'h4F39);
    wait_sel1(6'b010000);
`ifdef SEG_SCAN_LZ_BLANK_EN
    check("dut1_slot4", 64'(seg1), 64'h006D);
`else
    check("dut1_slot4", 64'(seg1), 64'h3F6D);
`endif
    wait_sel1(6'b000001);
    check("dut1_slot0_blank", 64'(seg1), 64'h0);

    // Reset during a sweep
    clr = 1'b1;
    tick();
    clr = 1'b0;
    tick();
    tick();
    check("sweep_in_progress", 64'(busy), 64'd1);
    reset = 1'b1;
    #2;
    check("midrst_seg", seg, 64'h0);
    check("midrst_slot_sel", 64'(slot_sel), 64'h01);
    check("midrst_wr_ready", 64'(wr_ready), 64'd1);
    check("midrst_busy", 64'(busy), 64'd0);
    model_reset();
    @(negedge clock);
    reset = 1'b0;
    repeat (40) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, err_count);
    $finish;
  end

endmodule
